// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: skips settling frames after SCCB config, then packs RGB565 byte pairs into pixels.
// Optional CMOS_LINE_CHECK_EN adds sticky line/frame geometry error flags.
module ov7670_capture #(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iConfig_Done,
  input  logic        iCMOS_VSYNC,
  input  logic        iCMOS_HREF,
  input  logic [7:0]  iCMOS_DATA,
  output logic [15:0] oPix_Data,
  output logic        oPix_Valid,
  output logic [10:0] oPix_X,
  output logic [9:0]  oPix_Y,
  output logic        oFrame_Start,
  output logic        oFrame_End,
  output logic [7:0]  oFrame_Cnt
`ifdef CMOS_LINE_CHECK_EN
  ,
  output logic        oLine_Err,
  output logic        oFrame_Err
`endif
);

  // state    | meaning
  // WAIT_CFG | sensor not configured, capture held idle
  // SKIP     | counting VSYNC rises while sensor settles
  // WAIT_VS  | no skip requested, waiting for first frame boundary
  // ACTIVE   | delivering pixels and frame markers
  typedef enum logic [1:0] {WAIT_CFG, SKIP, WAIT_VS, ACTIVE} state_t;

  localparam logic [10:0] H_MAX  = 11'(H_DISP);
  localparam logic [9:0]  V_MAX  = 10'(V_DISP);
  localparam logic [7:0]  SKIP_N = 8'(SKIP_FRAMES);

  state_t      r_state;
  logic        r_vs_s1, r_vs_s2, r_href_s1, r_href_s2;
  logic [7:0]  r_data_s1, r_hi, r_skip_cnt;
  logic        r_phase, r_start_pend;
  logic [10:0] r_x;
  logic [9:0]  r_y;

  logic       w_vs_rise, w_href_fall;
  logic [7:0] w_skip_next;

  assign w_vs_rise   = r_vs_s1 & ~r_vs_s2;
  assign w_href_fall = ~r_href_s1 & r_href_s2;
  assign w_skip_next = r_skip_cnt + 8'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= WAIT_CFG;
      r_vs_s1      <= 1'b0;
      r_vs_s2      <= 1'b0;
      r_href_s1    <= 1'b0;
      r_href_s2    <= 1'b0;
      r_data_s1    <= 8'd0;
      r_hi         <= 8'd0;
      r_skip_cnt   <= 8'd0;
      r_phase      <= 1'b0;
      r_start_pend <= 1'b0;
      r_x          <= 11'd0;
      r_y          <= 10'd0;
      oPix_Data    <= 16'd0;
      oPix_Valid   <= 1'b0;
      oPix_X       <= 11'd0;
      oPix_Y       <= 10'd0;
      oFrame_Start <= 1'b0;
      oFrame_End   <= 1'b0;
      oFrame_Cnt   <= 8'd0;
    end else begin
      r_vs_s1      <= iCMOS_VSYNC;
      r_vs_s2      <= r_vs_s1;
      r_href_s1    <= iCMOS_HREF;
      r_href_s2    <= r_href_s1;
      r_data_s1    <= iCMOS_DATA;
      oPix_Valid   <= 1'b0;
      oFrame_Start <= 1'b0;
      oFrame_End   <= 1'b0;
      r_start_pend <= 1'b0;
      if (!iConfig_Done) begin
        r_state <= WAIT_CFG;
        r_phase <= 1'b0;
      end else begin
        case (r_state)
          WAIT_CFG: begin
            r_skip_cnt <= 8'd0;
            r_state    <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
          end
          SKIP, WAIT_VS: begin
            if (w_vs_rise) begin
              r_skip_cnt <= w_skip_next;
              if (r_state == WAIT_VS || w_skip_next == SKIP_N) begin
                r_state      <= ACTIVE;
                oFrame_Start <= 1'b1;
                r_x          <= 11'd0;
                r_y          <= 10'd0;
                r_phase      <= 1'b0;
              end
            end
          end
          ACTIVE: begin
            if (r_start_pend) oFrame_Start <= 1'b1;
            if (w_vs_rise) begin
              // End of frame now, start of the next one on the following cycle
              oFrame_End   <= 1'b1;
              oFrame_Cnt   <= oFrame_Cnt + 8'd1;
              r_start_pend <= 1'b1;
              r_x          <= 11'd0;
              r_y          <= 10'd0;
              r_phase      <= 1'b0;
            end else if (w_href_fall) begin
              r_x     <= 11'd0;
              r_phase <= 1'b0;
              if (r_y < V_MAX) r_y <= r_y + 10'd1;
            end else if (r_href_s1) begin
              if (!r_phase) begin
                r_hi    <= r_data_s1;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_x < H_MAX && r_y < V_MAX) begin
                  oPix_Valid <= ~r_start_pend;
                  oPix_Data  <= {r_hi, r_data_s1};
                  oPix_X     <= r_x;
                  oPix_Y     <= r_y;
                  r_x        <= r_x + 11'd1;
                end
              end
            end
          end
          default: r_state <= WAIT_CFG;
        endcase
      end
    end
  end

`ifdef CMOS_LINE_CHECK_EN
  localparam logic [11:0] LINE_BYTES = 12'(2 * H_DISP);
  logic [11:0] r_byte_cnt;
  logic [9:0]  r_line_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST || r_state == WAIT_CFG) begin
      oLine_Err  <= 1'b0;
      oFrame_Err <= 1'b0;
    end else if (r_state == ACTIVE && iConfig_Done) begin
      if (w_vs_rise && r_line_cnt != V_MAX) oFrame_Err <= 1'b1;
      if (!w_vs_rise && w_href_fall && r_byte_cnt != LINE_BYTES) oLine_Err <= 1'b1;
    end
  end

  // Geometry counters restart on every frame entry and boundary
  always_ff @(posedge iCLK) begin
    if (iRST || r_state != ACTIVE || !iConfig_Done || w_vs_rise) begin
      r_byte_cnt <= 12'd0;
      r_line_cnt <= 10'd0;
    end else if (w_href_fall) begin
      r_byte_cnt <= 12'd0;
      if (r_line_cnt != 10'h3FF) r_line_cnt <= r_line_cnt + 10'd1;
    end else if (r_href_s1 && r_byte_cnt != 12'hFFF) begin
      r_byte_cnt <= r_byte_cnt + 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: one instance skipping 2 frames, one with no skip, fed identical streams.
module tb_ov7670_capture;
  localparam int H = 4;
  localparam int V = 2;

  logic iCLK = 1'b0;
  logic iRST, iConfig_Done, vs, href;
  logic [7:0] data;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_fs, b_fs, a_fe, b_fe;
  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic [7:0]  a_cnt, b_cnt;
`ifdef CMOS_LINE_CHECK_EN
  logic a_line_err, a_frame_err, b_line_err, b_frame_err;
`endif

  always #5 iCLK = ~iCLK;

  ov7670_capture #(.H_DISP(H), .V_DISP(V), .SKIP_FRAMES(2)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iConfig_Done(iConfig_Done),
    .iCMOS_VSYNC(vs), .iCMOS_HREF(href), .iCMOS_DATA(data),
    .oPix_Data(a_data), .oPix_Valid(a_valid), .oPix_X(a_x), .oPix_Y(a_y),
    .oFrame_Start(a_fs), .oFrame_End(a_fe),
`ifdef CMOS_LINE_CHECK_EN
    .oLine_Err(a_line_err), .oFrame_Err(a_frame_err),
`endif
    .oFrame_Cnt(a_cnt));

  ov7670_capture #(.H_DISP(H), .V_DISP(V), .SKIP_FRAMES(0)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iConfig_Done(iConfig_Done),
    .iCMOS_VSYNC(vs), .iCMOS_HREF(href), .iCMOS_DATA(data),
    .oPix_Data(b_data), .oPix_Valid(b_valid), .oPix_X(b_x), .oPix_Y(b_y),
    .oFrame_Start(b_fs), .oFrame_End(b_fe),
`ifdef CMOS_LINE_CHECK_EN
    .oLine_Err(b_line_err), .oFrame_Err(b_frame_err),
`endif
    .oFrame_Cnt(b_cnt));

  typedef struct {
    logic [15:0] data;
    logic [10:0] x;
    logic [9:0]  y;
    longint      t;
  } pix_t;

  typedef struct {
    logic [7:0]  b_hi;
    logic [7:0]  b_lo;
    logic [15:0] exp_data;
    logic [10:0] exp_x;
  } pk_t;

  pix_t cap_a[$], cap_b[$], exp_q[$];
  longint t2_log[$];
  logic [7:0] lb[$];
  int checks = 0, failures = 0;
  int fs_a = 0, fe_a = 0, fs_b = 0, fe_b = 0, clash = 0;
  longint t_fs_a = 0, t_fe_a = 0, t_fs_b = 0, t_fe_b = 0;
  logic [7:0] cnt_a_at_fe = 0, cnt_b_at_fe = 0;

  always @(negedge iCLK) begin
    if (!iRST) begin
      if (a_valid) cap_a.push_back('{data: a_data, x: a_x, y: a_y, t: longint'($time)});
      if (b_valid) cap_b.push_back('{data: b_data, x: b_x, y: b_y, t: longint'($time)});
      if (a_fs) begin fs_a++; t_fs_a = longint'($time); if (a_valid) clash++; end
      if (b_fs) begin fs_b++; t_fs_b = longint'($time); if (b_valid) clash++; end
      if (a_fe) begin fe_a++; t_fe_a = longint'($time); cnt_a_at_fe = a_cnt; end
      if (b_fe) begin fe_b++; t_fe_b = longint'($time); cnt_b_at_fe = b_cnt; end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] d);
    vs = v; href = h; data = d;
    @(negedge iCLK);
  endtask

  task automatic vs_pulse(output longint t);
    t = longint'($time);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic mk_line(input int n, input int seed);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'(seed + 17 * i));
  endtask

  // Drives one HREF burst; when asked, models the pixels a running capture should emit.
  task automatic line(input logic [7:0] b[$], input int y, input bit expect_px, input int drop_at);
    longint t2;
    t2_log.delete();
    for (int i = 0; i < b.size(); i++) begin
      if (drop_at >= 0 && i >= drop_at) iConfig_Done = 1'b0;
      t2 = longint'($time);
      if (i % 2 == 1) t2_log.push_back(t2);
      step(1'b0, 1'b1, b[i]);
      if (expect_px && i % 2 == 1 && (i / 2) < H && y < V && (drop_at < 0 || i + 1 < drop_at))
        exp_q.push_back('{data: {b[i-1], b[i]}, x: 11'(i / 2), y: 10'(y), t: t2 + 20});
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic cmp_pix(input string nm, input pix_t act[$], input pix_t e[$]);
    check({nm, ".count"}, act.size(), e.size());
    for (int i = 0; i < e.size() && i < act.size(); i++) begin
      check($sformatf("%s[%0d].data", nm, i), act[i].data, e[i].data);
      check($sformatf("%s[%0d].x", nm, i), act[i].x, e[i].x);
      check($sformatf("%s[%0d].y", nm, i), act[i].y, e[i].y);
      check($sformatf("%s[%0d].latency", nm, i), act[i].t, e[i].t);
    end
  endtask

  task automatic flush();
    cap_a.delete(); cap_b.delete(); exp_q.delete();
  endtask

  initial begin
    pk_t    pk[4];
    longint t;
    pk[0] = '{b_hi: 8'h12, b_lo: 8'h34, exp_data: 16'h1234, exp_x: 11'd0};
    pk[1] = '{b_hi: 8'h56, b_lo: 8'h78, exp_data: 16'h5678, exp_x: 11'd1};
    pk[2] = '{b_hi: 8'h9A, b_lo: 8'hBC, exp_data: 16'h9ABC, exp_x: 11'd2};
    pk[3] = '{b_hi: 8'hDE, b_lo: 8'hF0, exp_data: 16'hDEF0, exp_x: 11'd3};

    iRST = 1'b1; iConfig_Done = 1'b0; vs = 1'b0; href = 1'b0; data = 8'h00;
    repeat (3) @(negedge iCLK);
    check("rst.valid", a_valid, 0);
    check("rst.fs", a_fs, 0);
    check("rst.fe", a_fe, 0);
    check("rst.cnt", a_cnt, 0);
    check("rst.data", a_data, 0);
    check("rst.x", a_x, 0);
    check("rst.y", a_y, 0);
    check("rst.b_cnt", b_cnt, 0);
    iRST = 1'b0;

    // Sensor streaming while configuration is still low
    for (int f = 0; f < 3; f++) begin
      vs_pulse(t);
      mk_line(8, 8'h10); line(lb, 0, 1'b0, -1); line(lb, 1, 1'b0, -1);
    end
    check("cfglow.a_pix", cap_a.size(), 0);
    check("cfglow.b_pix", cap_b.size(), 0);
    check("cfglow.a_fs", fs_a, 0);
    check("cfglow.a_fe", fe_a, 0);
    check("cfglow.b_fs", fs_b, 0);
    check("cfglow.b_fe", fe_b, 0);
    check("cfglow.a_cnt", a_cnt, 0);
    check("cfglow.b_cnt", b_cnt, 0);

    iConfig_Done = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    vs_pulse(t);
    check("vs1.a_fs", fs_a, 0);
    check("vs1.b_fs", fs_b, 1);
    check("vs1.b_fs_time", t_fs_b, t + 20);
    check("vs1.b_fe", fe_b, 0);
    mk_line(8, 8'h21); line(lb, 0, 1'b1, -1);
    mk_line(8, 8'h40); line(lb, 1, 1'b1, -1);
    cmp_pix("skip0_frame", cap_b, exp_q);
    check("vs1.a_pix", cap_a.size(), 0);
    flush();

    vs_pulse(t);
    check("vs2.a_fs", fs_a, 1);
    check("vs2.a_fs_time", t_fs_a, t + 20);
    check("vs2.a_fe", fe_a, 0);
    check("vs2.b_fe", fe_b, 1);
    check("vs2.b_fe_time", t_fe_b, t + 20);
    check("vs2.b_fs_time", t_fs_b, t + 30);
    check("vs2.b_cnt_at_fe", cnt_b_at_fe, 1);

    lb.delete();
    for (int i = 0; i < 4; i++) begin lb.push_back(pk[i].b_hi); lb.push_back(pk[i].b_lo); end
    line(lb, 0, 1'b0, -1);
    check("pack.count", cap_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_a.size()) begin
        check($sformatf("pack[%0d].data", i), cap_a[i].data, pk[i].exp_data);
        check($sformatf("pack[%0d].x", i), cap_a[i].x, pk[i].exp_x);
        check($sformatf("pack[%0d].y", i), cap_a[i].y, 0);
        check($sformatf("pack[%0d].latency", i), cap_a[i].t, t2_log[i] + 20);
      end
    end
    flush();
    mk_line(8, 8'h61); line(lb, 1, 1'b1, -1);
    mk_line(8, 8'h81); line(lb, 2, 1'b1, -1);
    cmp_pix("ysat", cap_a, exp_q);
`ifdef CMOS_LINE_CHECK_EN
    check("lerr.clean", a_line_err, 0);
`endif
    flush();

    vs_pulse(t);
    check("vs3.a_fe", fe_a, 1);
    check("vs3.a_fe_time", t_fe_a, t + 20);
    check("vs3.a_cnt_at_fe", cnt_a_at_fe, 1);
    check("vs3.a_fs", fs_a, 2);
    check("vs3.a_fs_time", t_fs_a, t + 30);
    mk_line(7, 8'hA0); line(lb, 0, 1'b1, -1);
    mk_line(10, 8'hC0); line(lb, 1, 1'b1, -1);
    cmp_pix("oddlong", cap_a, exp_q);
`ifdef CMOS_LINE_CHECK_EN
    check("lerr.set", a_line_err, 1);
`endif
    flush();

    vs_pulse(t);
    check("vs4.a_fe", fe_a, 2);
    check("vs4.a_cnt", a_cnt, 2);
    check("vs4.a_fs", fs_a, 3);
    check("vs4.b_cnt", b_cnt, 3);

    // Configuration lost mid-line after two pixels
    mk_line(8, 8'h31); line(lb, 0, 1'b1, 5);
    cmp_pix("drop_a", cap_a, exp_q);
    cmp_pix("drop_b", cap_b, exp_q);
    flush();
    check("drop.a_fe", fe_a, 2);
    check("drop.b_fe", fe_b, 3);
    check("drop.a_cnt", a_cnt, 2);
    vs_pulse(t);
    check("drop.vs_ign_a", fs_a, 3);
    check("drop.vs_ign_b", fs_b, 4);

    iConfig_Done = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    vs_pulse(t);
    check("recfg.vs1_a_fs", fs_a, 3);
    check("recfg.vs1_b_fs", fs_b, 5);
    mk_line(8, 8'h55); line(lb, 0, 1'b0, -1);
    check("recfg.a_skip_pix", cap_a.size(), 0);
    flush();
    vs_pulse(t);
    check("recfg.vs2_a_fs", fs_a, 4);
    check("recfg.vs2_a_fs_time", t_fs_a, t + 20);
    check("recfg.a_fe", fe_a, 2);
    check("valid_vs_start_clash", clash, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
